mag_compare_seq: RTL and testbench
==================================

# mag_compare_seq

Multi-byte magnitude-compare sequencer that owns a single 8-bit compare slice and time-shares it across the bytes of two WIDTH-bit operands. It walks from the most significant byte to the least and stops at the first unequal byte. It returns a one-hot less/greater/equal result over a valid/ready handshake. It sits between the ALU control path and the byte compare datapath, replacing a wide combinational comparator chain with one slice plus sequencing.

## Interface
- WIDTH, 32, operand width in bits; multiple of 8, minimum 16; NB = WIDTH/8 bytes
- IDX_W, derived = max(1, clog2(NB)), width of byte index
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request pulse/level; sampled only in IDLE
- a  in  WIDTH  operand A; captured on accepted start
- b  in  WIDTH  operand B; captured on accepted start
- enable  in  1  slice enable; low stalls RUN (no byte consumed)
- res_ready  in  1  consumer accepts result
- busy  out  1  high in RUN and DONE
- res_valid  out  1  result valid (DONE state)
- lt  out  1  A < B
- gt  out  1  A > B
- eq  out  1  A == B
- dec_idx  out  IDX_W  byte index that decided result (0 = LSB byte)

## Operation
- States: IDLE, RUN, DONE.
- IDLE: busy=0, res_valid=0. On start=1, latch a/b into internal registers, set idx=NB-1, go RUN. Input a/b ignored afterwards.
- RUN, enable=1: compare byte idx of latched A and B, one byte per cycle.
  - If A>B: set gt=1, dec_idx=idx, go DONE.
  - If A<B: set lt=1, dec_idx=idx, go DONE.
  - If equal and idx=0: set eq=1, dec_idx=0, go DONE.
  - Otherwise decrement idx and stay in RUN.
- RUN, enable=0: hold idx and state; no compare, no output change.
- DONE: res_valid=1 with lt/gt/eq/dec_idx held stable. When res_ready=1, go IDLE and clear lt/gt/eq/res_valid. dec_idx holds its last value.
- start is ignored in RUN and DONE. No queuing: start must be presented again in IDLE.
- Exactly one of lt/gt/eq is high whenever res_valid=1. All three are 0 otherwise.
- Byte compare is unsigned 8-bit. Results of more significant bytes dominate, so early exit is mandatory.

## Timing
- Reset (reset_n=0, any state, asynchronous): state=IDLE, busy=0, res_valid=0, lt=gt=eq=0, dec_idx=0, idx=0, operand registers cleared. A comparison in progress is discarded.
- Start accepted at rising edge E0. The first compare happens at E1. The result decided by byte j (counted from MSB, j=0 for MSB) registers at edge E(j+1). res_valid is high from E(j+1).
- Latency: k+1 cycles from start edge to res_valid, where k = number of enabled RUN cycles used (1..NB). Maximum NB+1; each enable-low cycle adds 1.
- res_ready high at or before res_valid rise: res_valid stays high for exactly one cycle, then IDLE. A new start can be accepted on the following edge.
- Back-to-back minimum period: NB+2 cycles worst case, 3 cycles when the MSB byte differs.
- Outputs are registered; none is combinational from inputs.

## Configuration
- CMP_SIGNED_EN defined: operands are two's complement. The MSB byte compare inspects bit WIDTH-1 first:
  - If the sign bits differ, the operand with sign=1 is less; result decided at idx=NB-1.
  - If the sign bits match, the unsigned byte walk applies unchanged.
- CMP_SIGNED_EN undefined: purely unsigned comparison; no sign logic synthesized.

## Test plan
- WIDTH=32, a=0x12345678, b=0x12345678, enable=1 -> eq=1, lt=gt=0, dec_idx=0, res_valid rises 5 edges after start edge (4 RUN cycles + 1).
- a=0x80000000, b=0x7FFFFFFF -> unsigned build: gt=1, dec_idx=3, res_valid after 1 RUN cycle. With CMP_SIGNED_EN: lt=1, dec_idx=3.
- a=0x123456FF, b=0x12345700 -> lt=1, dec_idx=1 after 3 RUN cycles. Then hold res_ready=0 for 5 cycles -> outputs stable and start pulses ignored. Then res_ready=1 -> IDLE next edge.
- Same operands as the first scenario with enable=0 for 2 cycles mid-RUN -> eq=1, latency increases by exactly 2, dec_idx=0.
- Drop reset_n low during RUN (idx=2) -> busy, res_valid, lt/gt/eq and dec_idx all 0 immediately without waiting for a clock edge. After release, start with a=0x00000001, b=0x00000002 -> lt=1, dec_idx=0.
- Start held high through RUN with changing a/b -> result reflects only the operands latched at acceptance. A second comparison begins only after returning to IDLE.

Source files
------------

// File: rtl/mag_compare_seq.sv
// Multi-byte magnitude-compare sequencer: one 8-bit compare slice walked MSB->LSB with early exit.
// Optional two's-complement ordering when CMP_SIGNED_EN is defined; unsigned otherwise.
module mag_compare_seq #(
  parameter int WIDTH = 32,
  localparam int NB = WIDTH / 8,
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             enable,
  input  logic             res_ready,
  output logic             busy,
  output logic             res_valid,
  output logic             lt,
  output logic             gt,
  output logic             eq,
  output logic [IDX_W-1:0] dec_idx
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_opA;
  logic [WIDTH-1:0] r_opB;
  logic [IDX_W-1:0] r_idx;

  logic [WIDTH-1:0] w_shA;
  logic [WIDTH-1:0] w_shB;
  logic [7:0]       w_byteA;
  logic [7:0]       w_byteB;
  logic             w_aLess;
  logic             w_aGreater;

  assign w_shA   = r_opA >> {r_idx, 3'b000};
  assign w_shB   = r_opB >> {r_idx, 3'b000};
  assign w_byteA = w_shA[7:0];
  assign w_byteB = w_shB[7:0];

  // Byte slice; in the signed build a sign mismatch on the top byte overrides the magnitude.
  always_comb begin
    w_aLess    = (w_byteA < w_byteB);
    w_aGreater = (w_byteA > w_byteB);
`ifdef CMP_SIGNED_EN
    if ((r_idx == LAST_IDX) && (r_opA[WIDTH-1] != r_opB[WIDTH-1])) begin
      w_aLess    = r_opA[WIDTH-1];
      w_aGreater = r_opB[WIDTH-1];
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_opA     <= '0;
      r_opB     <= '0;
      r_idx     <= '0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      lt        <= 1'b0;
      gt        <= 1'b0;
      eq        <= 1'b0;
      dec_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_opA   <= a;
            r_opB   <= b;
            r_idx   <= LAST_IDX;
            busy    <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (enable) begin
            if (w_aGreater) begin
              gt        <= 1'b1;
              dec_idx   <= r_idx;
              res_valid <= 1'b1;
              r_state   <= S_DONE;
            end else if (w_aLess) begin
              lt        <= 1'b1;
              dec_idx   <= r_idx;
              res_valid <= 1'b1;
              r_state   <= S_DONE;
            end else if (r_idx == '0) begin
              eq        <= 1'b1;
              dec_idx   <= '0;
              res_valid <= 1'b1;
              r_state   <= S_DONE;
            end else begin
              r_idx <= r_idx - IDX_W'(1);
            end
          end
        end
        S_DONE: begin
          if (res_ready) begin
            lt        <= 1'b0;
            gt        <= 1'b0;
            eq        <= 1'b0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mag_compare_seq.sv
// Self-checking bench for mag_compare_seq (WIDTH=32): directed table, corner sequences, random vs. model.
module tb_mag_compare_seq;

  localparam int WIDTH = 32;
  localparam int NB = WIDTH / 8;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        enable;
  logic        res_ready;
  logic        busy;
  logic        res_valid;
  logic        lt;
  logic        gt;
  logic        eq;
  logic [1:0]  dec_idx;

  int testsRun;
  int testsFailed;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        lt;
    logic        gt;
    logic        eq;
    logic [1:0]  idx;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  mag_compare_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .a(a),
    .b(b),
    .enable(enable),
    .res_ready(res_ready),
    .busy(busy),
    .res_valid(res_valid),
    .lt(lt),
    .gt(gt),
    .eq(eq),
    .dec_idx(dec_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one request; lat counts edges from the start edge (inclusive) until res_valid is seen.
  task automatic applyStimulus(input logic [31:0] ta, input logic [31:0] tb, input int stallAt,
                               input int stallLen, input bit holdStart, output int lat,
                               output bit timedOut);
    start  = 1'b1;
    a      = ta;
    b      = tb;
    enable = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    if (!holdStart) start = 1'b0;
    while (!res_valid && lat < 64) begin
      enable = !(lat >= stallAt && lat < stallAt + stallLen);
      if (holdStart) begin
        a = $urandom;
        b = $urandom;
      end
      @(posedge clk); #1;
      lat++;
    end
    enable   = 1'b1;
    timedOut = !res_valid;
  endtask

  // Reference ordering from whole-word arithmetic; deciding byte is the most significant differing one.
  function automatic void refModel(input logic [31:0] x, input logic [31:0] y, output logic mLt,
                                   output logic mGt, output logic mEq, output int mIdx,
                                   output int mLat);
    mIdx = 0;
    for (int j = NB - 1; j >= 0; j--) begin
      if (x[j*8 +: 8] != y[j*8 +: 8]) begin
        mIdx = j;
        break;
      end
    end
`ifdef CMP_SIGNED_EN
    mLt = ($signed(x) < $signed(y));
    mGt = ($signed(x) > $signed(y));
`else
    mLt = (x < y);
    mGt = (x > y);
`endif
    mEq = (x == y);
    mLat = mEq ? NB + 1 : (NB - mIdx) + 1;
  endfunction

  task automatic checkReturnIdle(input string tag);
    @(posedge clk); #1;
    checkOutput({tag, "_idleValid"}, 32'(res_valid), 32'd0);
    checkOutput({tag, "_idleBusy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_idleFlags"}, {29'd0, lt, gt, eq}, 32'd0);
  endtask

  initial begin
    int          lat;
    bit          tmo;
    logic        mLt, mGt, mEq;
    int          mIdx, mLat, stallLen, r;
    logic [31:0] ra, rb;

    testsRun    = 0;
    testsFailed = 0;

    vecs[0] = '{32'h12345678, 32'h12345678, 1'b0, 1'b0, 1'b1, 2'd0, 5};
`ifdef CMP_SIGNED_EN
    vecs[1] = '{32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 2'd3, 2};
    vecs[4] = '{32'hFF000000, 32'h00000000, 1'b1, 1'b0, 1'b0, 2'd3, 2};
`else
    vecs[1] = '{32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 2'd3, 2};
    vecs[4] = '{32'hFF000000, 32'h00000000, 1'b0, 1'b1, 1'b0, 2'd3, 2};
`endif
    vecs[2] = '{32'h123456FF, 32'h12345700, 1'b1, 1'b0, 1'b0, 2'd1, 4};
    vecs[3] = '{32'h00000001, 32'h00000002, 1'b1, 1'b0, 1'b0, 2'd0, 5};
    vecs[5] = '{32'h0000AB00, 32'h0000AA00, 1'b0, 1'b1, 1'b0, 2'd1, 4};
    vecs[6] = '{32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1, 2'd0, 5};
    vecs[7] = '{32'h00120000, 32'h00130000, 1'b1, 1'b0, 1'b0, 2'd2, 3};

    reset_n   = 1'b0;
    start     = 1'b0;
    a         = '0;
    b         = '0;
    enable    = 1'b1;
    res_ready = 1'b1;
    #1;
    checkOutput("resetOutputs", {25'd0, busy, res_valid, lt, gt, eq, dec_idx}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].a, vecs[i].b, 0, 0, 1'b0, lat, tmo);
      checkOutput($sformatf("vec%0d_timeout", i), 32'(tmo), 32'd0);
      checkOutput($sformatf("vec%0d_lt", i), 32'(lt), 32'(vecs[i].lt));
      checkOutput($sformatf("vec%0d_gt", i), 32'(gt), 32'(vecs[i].gt));
      checkOutput($sformatf("vec%0d_eq", i), 32'(eq), 32'(vecs[i].eq));
      checkOutput($sformatf("vec%0d_idx", i), 32'(dec_idx), 32'(vecs[i].idx));
      checkOutput($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      checkOutput($sformatf("vec%0d_busy", i), 32'(busy), 32'd1);
      checkReturnIdle($sformatf("vec%0d", i));
    end

    // Equal operands with two stalled edges in the middle of the walk.
    applyStimulus(32'h12345678, 32'h12345678, 2, 2, 1'b0, lat, tmo);
    checkOutput("stall_timeout", 32'(tmo), 32'd0);
    checkOutput("stall_eq", {29'd0, lt, gt, eq}, 32'd1);
    checkOutput("stall_idx", 32'(dec_idx), 32'd0);
    checkOutput("stall_lat", 32'(lat), 32'd7);
    checkReturnIdle("stall");

    // Result held while the consumer back-pressures; start pulses meanwhile are ignored.
    res_ready = 1'b0;
    applyStimulus(32'h123456FF, 32'h12345700, 0, 0, 1'b0, lat, tmo);
    checkOutput("hold_timeout", 32'(tmo), 32'd0);
    for (int c = 0; c < 5; c++) begin
      start = c[0];
      a     = 32'hFFFFFFFF;
      b     = 32'h00000000;
      @(posedge clk); #1;
      checkOutput($sformatf("hold%0d_valid", c), 32'(res_valid), 32'd1);
      checkOutput($sformatf("hold%0d_flags", c), {29'd0, lt, gt, eq}, 32'b100);
      checkOutput($sformatf("hold%0d_idx", c), 32'(dec_idx), 32'd1);
    end
    start     = 1'b0;
    res_ready = 1'b1;
    checkReturnIdle("hold");

    // Asynchronous reset mid-walk: clears outputs without a clock edge.
    start = 1'b1;
    a     = 32'h12345678;
    b     = 32'h12345678;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    checkOutput("preReset_busy", 32'(busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("asyncReset_outputs", {25'd0, busy, res_valid, lt, gt, eq, dec_idx}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    applyStimulus(32'h00000001, 32'h00000002, 0, 0, 1'b0, lat, tmo);
    checkOutput("postReset_timeout", 32'(tmo), 32'd0);
    checkOutput("postReset_flags", {29'd0, lt, gt, eq}, 32'b100);
    checkOutput("postReset_idx", 32'(dec_idx), 32'd0);
    checkOutput("postReset_lat", 32'(lat), 32'd5);
    checkReturnIdle("postReset");

    // start held high with changing operands: only the accepted pair matters, then IDLE before reaccept.
    applyStimulus(32'h00000005, 32'h00000003, 0, 0, 1'b1, lat, tmo);
    checkOutput("holdStart_timeout", 32'(tmo), 32'd0);
    checkOutput("holdStart_flags", {29'd0, lt, gt, eq}, 32'b010);
    checkOutput("holdStart_idx", 32'(dec_idx), 32'd0);
    checkOutput("holdStart_lat", 32'(lat), 32'd5);
    @(posedge clk); #1;
    checkOutput("holdStart_idle", {30'd0, busy, res_valid}, 32'd0);
    @(posedge clk); #1;
    checkOutput("holdStart_reaccept", 32'(busy), 32'd1);
    start = 1'b0;
    r = 0;
    while (!res_valid && r < 64) begin
      @(posedge clk); #1;
      r++;
    end
    checkOutput("holdStart_secondDone", 32'(res_valid), 32'd1);
    checkReturnIdle("holdStart");

    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      rb = $urandom;
      r  = $urandom_range(0, 4);
      for (int j = 0; j < NB; j++) begin
        if (j > r) rb[j*8 +: 8] = ra[j*8 +: 8];
      end
      if (r == 4) rb = ra;
      stallLen = $urandom_range(0, 2);
      refModel(ra, rb, mLt, mGt, mEq, mIdx, mLat);
      applyStimulus(ra, rb, 1, stallLen, 1'b0, lat, tmo);
      checkOutput($sformatf("rnd%0d_timeout", n), 32'(tmo), 32'd0);
      checkOutput($sformatf("rnd%0d_flags", n), {29'd0, lt, gt, eq}, {29'd0, mLt, mGt, mEq});
      checkOutput($sformatf("rnd%0d_idx", n), 32'(dec_idx), 32'(mIdx));
      checkOutput($sformatf("rnd%0d_lat", n), 32'(lat), 32'(mLat + stallLen));
      checkReturnIdle($sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
